pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. It sequences the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC. It detects load-use hazards, flushes on a taken branch resolved in MEM, and freezes the pipeline while a data-memory access is outstanding. It also keeps saturating stall and flush event counters, and raises a sticky error if memory never answers.

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 33 +++
 rtl/pipeline_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipeline_ctrl_pkg;

    // Controller states; ERROR is only left through reset
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_e;

    localparam int          DEF_MEM_TIMEOUT = 64;
    localparam int          DEF_CNT_W       = 32;
    localparam logic [4:0]  REG_X0          = 5'd0;

    // A load into x0 never creates a real dependency
    function automatic logic is_load_use(input logic       mem_read,
                                         input logic [4:0] rd,
                                         input logic [4:0] rs1,
                                         input logic [4:0] rs2);
        return mem_read && (rd != REG_X0) && ((rd == rs1) || (rd == rs2));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request, holding once all-ones is reached
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencing for the 5-stage pipeline
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       IF_ID_RS1,
    input  logic [4:0]       IF_ID_RS2,
    input  logic [4:0]       ID_EX_RD,
    input  logic             ID_EX_MemRead,
    input  logic             BranchTaken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Flush,
    output logic             Pipe_Hold,
    output logic             ctrl_error,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    // Wide enough to hold any count reached before the timeout fires
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    ctrl_state_e   state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          ctrl_error_q, ctrl_error_d;

    logic freeze;
    logic normal;
    logic load_use;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pipe_hold;
    logic branch_flush;

    assign load_use = is_load_use(ID_EX_MemRead, ID_EX_RD, IF_ID_RS1, IF_ID_RS2);

    // Next state, wait counter and freeze/normal-priority selection
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        normal     = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    freeze     = 1'b1;
                    wait_cnt_d = '0;
                    // The RUN cycle already counts as the first unanswered cycle
                    state_d    = (MEM_TIMEOUT <= 1) ? ERROR : MEM_WAIT;
                end else begin
                    normal = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    freeze = 1'b1;
                    if ((int'(wait_cnt_q) + 2) >= MEM_TIMEOUT) begin
                        state_d = ERROR;
                    end else begin
                        wait_cnt_d = wait_cnt_q + {{(WW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    normal     = 1'b1;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERROR: begin
                freeze = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Pipeline register controls: freeze > branch flush > load-use, forced while in reset
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        pipe_hold    = 1'b0;
        branch_flush = 1'b0;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (freeze) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end else if (normal && BranchTaken) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            exmem_flush  = 1'b1;
            branch_flush = 1'b1;
        end else if (normal && load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Error flag latches on entry to ERROR and stays until reset
    always_comb begin
        ctrl_error_d = ctrl_error_q;
        if (state_d == ERROR) begin
            ctrl_error_d = 1'b1;
        end
    end

    // State, wait counter and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            ctrl_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            ctrl_error_q <= ctrl_error_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_flush),
        .count (flush_count)
    );

    assign PCWrite      = pc_write;
    assign IF_ID_Write  = ifid_write;
    assign IF_ID_Flush  = ifid_flush;
    assign ID_EX_Flush  = idex_flush;
    assign EX_MEM_Flush = exmem_flush;
    assign Pipe_Hold    = pipe_hold;
    assign ctrl_error   = ctrl_error_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - randomized self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int T     = 6;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic [4:0]    rs1, rs2, rd;
    logic          memrd, br, mreq, mrdy;
    logic          pcw, ifidw, f_ifid, f_idex, f_exmem, hold, err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks;
    int n_errors;

    // Reference state: memory wait tracked as a run length of unanswered cycles
    bit m_wait;
    bit m_err;
    int m_low;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .IF_ID_RS1     (rs1),
        .IF_ID_RS2     (rs2),
        .ID_EX_RD      (rd),
        .ID_EX_MemRead (memrd),
        .BranchTaken   (br),
        .mem_req       (mreq),
        .mem_ready     (mrdy),
        .PCWrite       (pcw),
        .IF_ID_Write   (ifidw),
        .IF_ID_Flush   (f_ifid),
        .ID_EX_Flush   (f_idex),
        .EX_MEM_Flush  (f_exmem),
        .Pipe_Hold     (hold),
        .ctrl_error    (err),
        .stall_count   (stall_cnt),
        .flush_count   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ctl_vec();
        return {pcw, ifidw, f_ifid, f_idex, f_exmem, hold};
    endfunction

    task automatic model_reset();
        m_wait  = 0;
        m_err   = 0;
        m_low   = 0;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Check one cycle against the reference, then advance both across the edge
    task automatic step();
        bit frz, flush, lu;
        logic [5:0] exp;
        lu    = memrd && (rd != 0) && (rd == rs1 || rd == rs2);
        frz   = m_err || (!m_wait && mreq && !mrdy) || (m_wait && !mrdy);
        flush = !frz && br;
        if (frz)        exp = 6'b000001;
        else if (flush) exp = 6'b111110;
        else if (lu)    exp = 6'b000100;
        else            exp = 6'b110000;
        #1;
        check("ctl", 32'(ctl_vec()), 32'(exp));
        check("ctrl_error", 32'(err), 32'(m_err));
        check("stall_count", 32'(stall_cnt), 32'(m_stall));
        check("flush_count", 32'(flush_cnt), 32'(m_flush));
        @(posedge clk);
        #1;
        if (exp[5] == 1'b0 && m_stall < CMAX) m_stall++;
        if (flush && m_flush < CMAX) m_flush++;
        if (!m_err) begin
            if (frz) begin
                m_low = m_wait ? m_low + 1 : 1;
                if (m_low >= T) begin
                    m_err  = 1;
                    m_wait = 0;
                end else begin
                    m_wait = 1;
                end
            end else begin
                m_wait = 0;
                m_low  = 0;
            end
        end
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_ctl", 32'(ctl_vec()), 32'(6'b001110));
        check("rst_stall", 32'(stall_cnt), 32'd0);
        check("rst_flush", 32'(flush_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        #2;
        reset = 1'b1;
    endtask

    task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input logic m, input logic bt, input logic q, input logic r);
        rs1 = a; rs2 = b; rd = d; memrd = m; br = bt; mreq = q; mrdy = r;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #2;
        check("rst_ctl", 32'(ctl_vec()), 32'(6'b001110));
        check("rst_stall", 32'(stall_cnt), 32'd0);
        #10;
        reset = 1'b1;

        // Load-use on rs1, then same pattern with rd = x0
        set_in(5, 1, 5, 1, 0, 0, 0); step();
        check("lu_stall1", 32'(stall_cnt), 32'd1);
        set_in(0, 2, 0, 1, 0, 0, 0); step();
        check("lu_x0", 32'(stall_cnt), 32'd1);

        // Branch and load-use together: flush only
        set_in(7, 3, 7, 1, 1, 0, 0); step();
        check("br_flush1", 32'(flush_cnt), 32'd1);
        check("br_stall", 32'(stall_cnt), 32'd1);

        // mem_req and mem_ready together: no freeze
        set_in(0, 0, 0, 0, 0, 1, 1); step();

        // Five unanswered cycles then ready with a held branch
        pulse_reset();
        for (int i = 0; i < T - 1; i++) begin
            set_in(1, 2, 3, 0, 1, 1, 0); step();
        end
        check("wait_stall5", 32'(stall_cnt), 32'(T - 1));
        set_in(1, 2, 3, 0, 1, 1, 1); step();
        check("wait_flush", 32'(flush_cnt), 32'd1);
        check("wait_err", 32'(err), 32'd0);

        // Reset in the middle of a memory wait
        set_in(0, 0, 0, 0, 0, 1, 0); step(); step();
        pulse_reset();
        set_in(0, 0, 0, 0, 0, 0, 0); step();

        // Stuck memory: timeout, ready ignored afterwards, counter saturates
        for (int i = 0; i < T; i++) begin
            set_in(0, 0, 0, 0, 0, 1, 0); step();
        end
        check("timeout_err", 32'(err), 32'd1);
        for (int i = 0; i < 14; i++) begin
            set_in(4, 4, 4, 1, 1, 1, 1); step();
        end
        check("sat_stall", 32'(stall_cnt), 32'(CMAX));
        check("err_sticky", 32'(err), 32'd1);
        pulse_reset();

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) pulse_reset();
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
